// File: rtl/cpu_types_pkg.sv
// Shared core types for the hazard control unit: sequencer states, decision rules,
// the stage-control bundle and the load-use comparator.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        FLUSH0 = 2'd0,
        RUN    = 2'd1,
        DWAIT  = 2'd2,
        HALTED = 2'd3
    } hz_state_t;

    // Which per-cycle rule produced the stage controls
    typedef enum logic [2:0] {
        HZ_R_NONE    = 3'd0,
        HZ_R_HALT    = 3'd1,
        HZ_R_DWAIT   = 3'd2,
        HZ_R_REDIR   = 3'd3,
        HZ_R_HOLD    = 3'd4,
        HZ_R_LOADUSE = 3'd5,
        HZ_R_IMISS   = 3'd6,
        HZ_R_ADVANCE = 3'd7
    } hz_rule_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctrl_t;

    localparam int HZ_CNT_W = 32;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    function automatic logic hz_load_use(input logic ex_memread, input regbits_t ex_rd,
                                         input regbits_t rs1, input regbits_t rs2);
        return ex_memread && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter used for stall and performance statistics.
import cpu_types_pkg::*;

module hz_sat_counter #(
    parameter int CNT_W = HZ_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: Mealy stage enables/flushes, data-wait watchdog and stall counter.
// Optional HAZARD_PERF_CNT_EN adds load-use, redirect and data-wait cycle counters.
import cpu_types_pkg::*;

module hazard_control_unit #(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = HZ_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             redirect_ex,
    input  logic             ihit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             dhit,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halt_out,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] dwait_cnt
`endif
);

    localparam int WC_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_LIMIT - 1);

    hz_state_t       state_r;
    hz_state_t       next_state_s;
    hz_rule_t        rule_s;
    hz_ctrl_t        ctrl_s;
    logic [WC_W-1:0] wait_cnt_r;
    logic            halt_out_r;
    logic            mem_timeout_r;
    logic            wait_s;
    logic            stall_inc_s;

    // Select stage controls from the current state and this cycle's hazards
    always_comb begin
        ctrl_s       = hz_ctrl_t'(7'b0000000);
        next_state_s = state_r;
        rule_s       = HZ_R_NONE;
        if (RST) begin
            ctrl_s       = hz_ctrl_t'(7'b0000000);
            next_state_s = FLUSH0;
        end else begin
            case (state_r)
                FLUSH0: begin
                    ctrl_s       = hz_ctrl_t'(7'b0111111);
                    next_state_s = RUN;
                end
                RUN, DWAIT: begin
                    next_state_s = RUN;
                    if (halt_mem) begin
                        rule_s       = HZ_R_HALT;
                        ctrl_s       = hz_ctrl_t'(7'b0000100);
                        next_state_s = HALTED;
                    end else if ((mem_dren || mem_dwen) && !dhit) begin
                        rule_s       = HZ_R_DWAIT;
                        ctrl_s       = hz_ctrl_t'(7'b0000000);
                        next_state_s = DWAIT;
                    end else if (redirect_ex && ihit) begin
                        rule_s = HZ_R_REDIR;
                        ctrl_s = hz_ctrl_t'(7'b1111111);
                    end else if (redirect_ex) begin
                        rule_s = HZ_R_HOLD;
                        ctrl_s = hz_ctrl_t'(7'b0000000);
                    end else if (hz_load_use(ex_memread, ex_rd, id_rs1, id_rs2)) begin
                        rule_s = HZ_R_LOADUSE;
                        ctrl_s = hz_ctrl_t'(7'b0011101);
                    end else if (!ihit) begin
                        rule_s = HZ_R_IMISS;
                        ctrl_s = hz_ctrl_t'(7'b0111110);
                    end else begin
                        rule_s = HZ_R_ADVANCE;
                        ctrl_s = hz_ctrl_t'(7'b1111100);
                    end
                end
                HALTED: begin
                    ctrl_s       = hz_ctrl_t'(7'b0000000);
                    next_state_s = HALTED;
                end
                default: begin
                    ctrl_s       = hz_ctrl_t'(7'b0000000);
                    next_state_s = FLUSH0;
                end
            endcase
        end
    end

    assign wait_s      = (rule_s == HZ_R_DWAIT);
    assign stall_inc_s = !ctrl_s.pc_en && (state_r != HALTED);

    // State, consecutive-wait tracking and sticky status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= FLUSH0;
            wait_cnt_r    <= '0;
            halt_out_r    <= 1'b0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (wait_s) begin
                if (wait_cnt_r != WAIT_LAST) begin
                    wait_cnt_r <= wait_cnt_r + WC_W'(1);
                end
                if (wait_cnt_r == WAIT_LAST) begin
                    mem_timeout_r <= 1'b1;
                end
            end else begin
                wait_cnt_r <= '0;
            end
            if (rule_s == HZ_R_HALT) begin
                halt_out_r <= 1'b1;
            end
        end
    end

    assign pc_en       = ctrl_s.pc_en;
    assign if_id_en    = ctrl_s.if_id_en;
    assign id_ex_en    = ctrl_s.id_ex_en;
    assign ex_mem_en   = ctrl_s.ex_mem_en;
    assign mem_wb_en   = ctrl_s.mem_wb_en;
    assign if_id_flush = ctrl_s.if_id_flush;
    assign id_ex_flush = ctrl_s.id_ex_flush;
    assign halt_out    = halt_out_r;
    assign mem_timeout = mem_timeout_r;

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .RST(RST), .inc(stall_inc_s), .clear(1'b0), .count(stall_cycles)
    );

`ifdef HAZARD_PERF_CNT_EN
    hz_sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
        .CLK(CLK), .RST(RST), .inc(rule_s == HZ_R_LOADUSE), .clear(1'b0), .count(loaduse_cnt)
    );
    hz_sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .CLK(CLK), .RST(RST), .inc(rule_s == HZ_R_REDIR), .clear(1'b0), .count(redirect_cnt)
    );
    hz_sat_counter #(.CNT_W(CNT_W)) u_dwait_cnt (
        .CLK(CLK), .RST(RST), .inc(wait_s), .clear(1'b0), .count(dwait_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (WAIT_LIMIT=4).
module tb_hazard_control_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, redirect_ex, ihit, mem_dren, mem_dwen, dhit, halt_mem;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic        halt_out, mem_timeout;
    logic [31:0] stall_cycles;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] loaduse_cnt, redirect_cnt, dwait_cnt;
`endif
    logic [6:0]  ctrl;
    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;

    hazard_control_unit #(.WAIT_LIMIT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .redirect_ex(redirect_ex), .ihit(ihit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .dhit(dhit), .halt_mem(halt_mem),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halt_out(halt_out), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
`ifdef HAZARD_PERF_CNT_EN
        , .loaduse_cnt(loaduse_cnt), .redirect_cnt(redirect_cnt), .dwait_cnt(dwait_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
        redirect_ex = 1'b0; ihit = 1'b1; mem_dren = 1'b0; mem_dwen = 1'b0;
        dhit = 1'b0; halt_mem = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #3;
        checks++; if (ctrl !== 7'b0000000) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b0000000); end
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
        checks++; if ({halt_out, mem_timeout} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {halt_out, mem_timeout}); end
        adv();
        RST = 1'b0;
        #1;
        checks++; if (ctrl !== 7'b0111111) begin failures++; $display("FAIL flush0_ctrl got=%b exp=%b", ctrl, 7'b0111111); end
        exp_stall++;
        adv(); #1;
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL run_ctrl got=%b exp=%b", ctrl, 7'b1111100); end
        checks++; if (stall_cycles !== 32'd1) begin failures++; $display("FAIL first_stall got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_load_use();
        adv();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd3; #1;
        checks++; if ({pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} !== 6'b001101)
            begin failures++; $display("FAIL loaduse_rs2 got=%b exp=001101", {pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}); end
        exp_stall++;
        adv(); idle(); #1;
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL loaduse_one_bubble got=%b exp=%b", ctrl, 7'b1111100); end
        adv();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL loaduse_x0 got=%b exp=%b", ctrl, 7'b1111100); end
        adv();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd9; #1;
        checks++; if ({pc_en, if_id_en, id_ex_flush} !== 3'b001) begin failures++; $display("FAIL loaduse_rs1 got=%b exp=001", {pc_en, if_id_en, id_ex_flush}); end
        exp_stall++;
        adv();
        ex_memread = 1'b0; #1;
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL no_load_no_stall got=%b exp=%b", ctrl, 7'b1111100); end
        idle();
    endtask

    task automatic test_icache_miss();
        adv();
        ihit = 1'b0; #1;
        checks++; if (ctrl !== 7'b0111110) begin failures++; $display("FAIL imiss got=%b exp=%b", ctrl, 7'b0111110); end
        exp_stall++;
        adv(); idle(); #1;
    endtask

    task automatic test_dwait();
        adv();
        mem_dren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctrl !== 7'b0000000) begin failures++; $display("FAIL dwait_freeze%0d got=%b exp=%b", i, ctrl, 7'b0000000); end
            exp_stall++;
            adv();
        end
        dhit = 1'b1; #1;
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL dwait_exit got=%b exp=%b", ctrl, 7'b1111100); end
        adv(); idle(); ihit = 1'b0; #1;
        checks++; if (ctrl !== 7'b0111110) begin failures++; $display("FAIL dwait_back_run got=%b exp=%b", ctrl, 7'b0111110); end
        exp_stall++;
        checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL dwait_no_timeout got=%b exp=0", mem_timeout); end
        adv(); idle(); #1;
    endtask

    task automatic test_redirect();
        adv();
        redirect_ex = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctrl !== 7'b0000000) begin failures++; $display("FAIL redirect_hold%0d got=%b exp=%b", i, ctrl, 7'b0000000); end
            exp_stall++;
            adv();
        end
        ihit = 1'b1; #1;
        checks++; if (ctrl !== 7'b1111111) begin failures++; $display("FAIL redirect_take got=%b exp=%b", ctrl, 7'b1111111); end
        adv(); idle(); #1;
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL redirect_after got=%b exp=%b", ctrl, 7'b1111100); end
    endtask

    task automatic test_priority();
        adv();
        mem_dwen = 1'b1; dhit = 1'b0; redirect_ex = 1'b1; ex_memread = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; #1;
        checks++; if (ctrl !== 7'b0000000) begin failures++; $display("FAIL prio_wait_over_redirect got=%b exp=%b", ctrl, 7'b0000000); end
        exp_stall++;
        adv(); mem_dwen = 1'b0; #1;
        checks++; if (ctrl !== 7'b1111111) begin failures++; $display("FAIL prio_redirect_over_loaduse got=%b exp=%b", ctrl, 7'b1111111); end
        adv(); redirect_ex = 1'b0; ihit = 1'b0; #1;
        checks++; if (ctrl[6:3] !== 4'b0011 || ctrl[1:0] !== 2'b01) begin failures++; $display("FAIL prio_loaduse_over_imiss got=%b exp=0011x01", ctrl); end
        exp_stall++;
        adv(); idle(); #1;
    endtask

    task automatic test_watchdog();
        adv();
        mem_dwen = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({ctrl, mem_timeout} !== 8'b00000000) begin failures++; $display("FAIL wd_wait%0d got=%b exp=%b", i, {ctrl, mem_timeout}, 8'b00000000); end
            exp_stall++;
            adv();
        end
        dhit = 1'b1; #1;
        checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL wd_timeout_set got=%b exp=1", mem_timeout); end
        checks++; if (ctrl !== 7'b1111100) begin failures++; $display("FAIL wd_exit_ctrl got=%b exp=%b", ctrl, 7'b1111100); end
        adv(); idle(); #1;
        checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", mem_timeout); end
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL stall_total got=%0d exp=%0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_halt();
        adv();
        halt_mem = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; #1;
        checks++; if (ctrl !== 7'b0000100) begin failures++; $display("FAIL halt_ctrl got=%b exp=%b", ctrl, 7'b0000100); end
        checks++; if (halt_out !== 1'b0) begin failures++; $display("FAIL halt_out_early got=%b exp=0", halt_out); end
        exp_stall++;
        adv(); idle(); #1;
        checks++; if (halt_out !== 1'b1) begin failures++; $display("FAIL halt_out_set got=%b exp=1", halt_out); end
        redirect_ex = 1'b1; mem_dren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctrl !== 7'b0000000) begin failures++; $display("FAIL halted_ctrl%0d got=%b exp=%b", i, ctrl, 7'b0000000); end
            adv();
        end
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL halted_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
        #2 RST = 1'b1; #1;
        checks++; if ({halt_out, mem_timeout, ctrl} !== 9'b0) begin failures++; $display("FAIL rst_mid_halt got=%b exp=%b", {halt_out, mem_timeout, ctrl}, 9'b0); end
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rst_mid_halt_stall got=%0d exp=0", stall_cycles); end
    endtask

    task automatic test_reset_mid_dwait();
        idle();
        adv(); RST = 1'b0;
        adv();
        mem_dren = 1'b1; dhit = 1'b0;
        adv(); adv(); #1;
        checks++; if (ctrl !== 7'b0000000) begin failures++; $display("FAIL dwait_before_rst got=%b exp=%b", ctrl, 7'b0000000); end
        RST = 1'b1; #1;
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rst_mid_dwait_stall got=%0d exp=0", stall_cycles); end
        adv(); RST = 1'b0; #1;
        checks++; if (ctrl !== 7'b0111111) begin failures++; $display("FAIL rst_mid_dwait_flush0 got=%b exp=%b", ctrl, 7'b0111111); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_icache_miss();
        test_dwait();
        test_redirect();
        test_priority();
        test_watchdog();
        test_halt();
        test_reset_mid_dwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
